// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types for the data-memory controller.
// Access sizes, FSM states and lane helpers.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int LANES = 4;

    // Size 3 is illegal; halves and words must be naturally aligned.
    function automatic logic access_err(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic e;
        e = 1'b0;
        if (size == 2'd3)
            e = 1'b1;
        else if (size == SZ_HALF && off[0])
            e = 1'b1;
        else if (size == SZ_WORD && off != 2'd0)
            e = 1'b1;
        return e;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align: picks the addressed lane(s) out of a memory
// word and sign- or zero-extends them to a full load result.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] result
);

    logic [31:0] shifted;
    logic        sbit;

    // Right-align the addressed lane, then extend by access size.
    always_comb begin
        shifted = word >> {off, 3'b000};
        sbit    = 1'b0;
        result  = '0;
        case (size)
            SZ_BYTE: begin
                sbit   = ~uns & shifted[7];
                result = {{24{sbit}}, shifted[7:0]};
            end
            SZ_HALF: begin
                sbit   = ~uns & shifted[15];
                result = {{16{sbit}}, shifted[15:0]};
            end
            SZ_WORD: result = shifted;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-addressed data memory with valid/ready request and
// response channels, strobed stores, extended loads and wait states.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);
    localparam logic [3:0] CNT_INIT =
        (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    if (DATA_WIDTH != 32) begin : g_dw_chk
        $error("dmem_ctrl: DATA_WIDTH must be 32");
    end
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_ws_chk
        $error("dmem_ctrl: WAIT_STATES must be 0..15");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_e                state;
    state_e                state_nx;
    logic [3:0]            cnt;
    logic                  accept;
    logic                  err;
    logic [1:0]            off;
    logic [ADDR_WIDTH-3:0] idx;
    logic [LANES-1:0]      be;
    logic [DATA_WIDTH-1:0] wsh;
    logic [DATA_WIDTH-1:0] ld_val;

    assign off    = req_addr[1:0];
    assign idx    = req_addr[ADDR_WIDTH-1:2];
    assign err    = access_err(req_size, off);
    assign accept = req_valid && req_ready && rst_n;

    // Byte-lane strobes and lane-aligned store data.
    always_comb begin
        be  = '0;
        wsh = req_wdata << {off, 3'b000};
        case (req_size)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = 4'b0011 << {off[1], 1'b0};
            SZ_WORD: be = 4'b1111;
            default: be = '0;
        endcase
    end

    dmem_load_align u_align (
        .word   (mem[idx]),
        .off    (off),
        .size   (req_size),
        .uns    (req_unsigned),
        .result (ld_val)
    );

    // Store commits at the accept edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (accept && req_we && !err) begin
            for (int i = 0; i < LANES; i++) begin
                if (be[i])
                    mem[idx][8*i +: 8] <= wsh[8*i +: 8];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // FSM next-state: accept, optional wait, hold until consumed.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept)
                      state_nx = (WAIT_STATES > 0) ? WAIT : RESP;
            WAIT: if (cnt == 4'd0)
                      state_nx = RESP;
            RESP: if (rsp_ready)
                      state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // FSM outputs: handshake flags decoded from state.
    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
    end

    // Wait-state counter, loaded on accept.
    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= 4'd0;
        else if (accept)
            cnt <= CNT_INIT;
        else if (state == WAIT && cnt != 4'd0)
            cnt <= cnt - 4'd1;
    end

    // Response payload captured at accept and held through RESP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (accept) begin
            rsp_err   <= err;
            rsp_rdata <= (err || req_we) ? '0 : ld_val;
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: random and directed checks of dmem_ctrl against a
// byte-array reference model, at 0 and 3 wait states.
module tb_dmem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid    [2];
    logic        req_we       [2];
    logic [1:0]  req_size     [2];
    logic        req_unsigned [2];
    logic [11:0] req_addr     [2];
    logic [31:0] req_wdata    [2];
    logic        rsp_ready    [2];
    logic        req_ready    [2];
    logic        rsp_valid    [2];
    logic [31:0] rsp_rdata    [2];
    logic        rsp_err      [2];

    logic [7:0]  mref [2][64];
    int          n_cmp;
    int          n_bad;

    dmem_ctrl #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .WAIT_STATES(0)) u0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_size(req_size[0]),
        .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
        .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0])
    );

    dmem_ctrl #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .WAIT_STATES(3)) u3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_size(req_size[1]),
        .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
        .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: memory as a little-endian byte array.
    task automatic model(input int s, input logic we, input logic [1:0] sz,
                         input logic uns, input int a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er);
        int nb;
        longint v;
        nb = 1 << sz;
        er = (sz == 2'd3) || (a % nb != 0);
        rd = '0;
        if (er) return;
        if (we) begin
            for (int i = 0; i < nb; i++)
                mref[s][a + i] = wd[8*i +: 8];
        end else begin
            v = 0;
            for (int i = 0; i < nb; i++)
                v += longint'(mref[s][a + i]) << (8 * i);
            if (!uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
                v -= longint'(1) << (8 * nb);
            rd = v[31:0];
        end
    endtask

    // One request/response transaction with latency and hold checks.
    task automatic xact(input int s, input logic we, input logic [1:0] sz,
                        input logic uns, input int a, input logic [31:0] wd,
                        input int hold,
                        output logic [31:0] rd, output logic er);
        int n;
        int ws;
        ws = (s == 0) ? 0 : 3;
        @(negedge clk);
        req_valid[s]    = 1'b1;
        req_we[s]       = we;
        req_size[s]     = sz;
        req_unsigned[s] = uns;
        req_addr[s]     = 12'(a);
        req_wdata[s]    = wd;
        rsp_ready[s]    = 1'b0;
        n = 0;
        while (!req_ready[s] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_idle", 32'(req_ready[s]), 32'd1);
        @(posedge clk);
        #1;
        req_valid[s] = 1'b0;
        n = 0;
        while (!rsp_valid[s] && n < 40) begin
            chk("req_ready_busy", 32'(req_ready[s]), 32'd0);
            rsp_ready[s] = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", 32'(n), 32'(ws));
        rd = rsp_rdata[s];
        er = rsp_err[s];
        rsp_ready[s] = (hold == 0);
        if (hold > 0) begin
            req_valid[s] = 1'b1;
            req_we[s]    = 1'b1;
            req_size[s]  = 2'd2;
            req_addr[s]  = 12'h03C;
            req_wdata[s] = 32'h5A5A_5A5A;
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(rsp_valid[s]), 32'd1);
            chk("hold_rdata", rsp_rdata[s], rd);
            chk("hold_err", 32'(rsp_err[s]), 32'(er));
            chk("hold_ready", 32'(req_ready[s]), 32'd0);
        end
        req_valid[s] = 1'b0;
        rsp_ready[s] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[s] = 1'b0;
        chk("after_valid", 32'(rsp_valid[s]), 32'd0);
        chk("after_ready", 32'(req_ready[s]), 32'd1);
    endtask

    // Transaction plus comparison against the reference model.
    task automatic run(input int s, input logic we, input logic [1:0] sz,
                       input logic uns, input int a, input logic [31:0] wd,
                       input int hold,
                       output logic [31:0] rd, output logic er);
        logic [31:0] mrd;
        logic        mer;
        xact(s, we, sz, uns, a, wd, hold, rd, er);
        model(s, we, sz, uns, a, wd, mrd, mer);
        chk("rdata", rd, mrd);
        chk("err", 32'(er), 32'(mer));
    endtask

    logic [31:0] rd;
    logic        er;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            req_valid[s]    = 1'b0;
            req_we[s]       = 1'b0;
            req_size[s]     = 2'd0;
            req_unsigned[s] = 1'b0;
            req_addr[s]     = '0;
            req_wdata[s]    = '0;
            rsp_ready[s]    = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int s = 0; s < 2; s++) begin
            chk("rst_valid", 32'(rsp_valid[s]), 32'd0);
            chk("rst_rdata", rsp_rdata[s], 32'd0);
            chk("rst_err", 32'(rsp_err[s]), 32'd0);
            chk("rst_ready", 32'(req_ready[s]), 32'd1);
        end

        for (int s = 0; s < 2; s++)
            for (int w = 0; w < 16; w++)
                run(s, 1'b1, 2'd2, 1'b0, 4 * w, $urandom, 0, rd, er);

        run(0, 1'b1, 2'd2, 1'b0, 'h010, 32'hDEAD_BEEF, 0, rd, er);
        chk("st_word_err", 32'(er), 32'd0);
        run(0, 1'b0, 2'd2, 1'b0, 'h010, 32'h0, 0, rd, er);
        chk("ld_word", rd, 32'hDEAD_BEEF);
        run(0, 1'b1, 2'd0, 1'b0, 'h013, 32'h0000_0080, 0, rd, er);
        run(0, 1'b0, 2'd0, 1'b0, 'h013, 32'h0, 0, rd, er);
        chk("ld_byte_s", rd, 32'hFFFF_FF80);
        run(0, 1'b0, 2'd0, 1'b1, 'h013, 32'h0, 0, rd, er);
        chk("ld_byte_u", rd, 32'h0000_0080);
        run(0, 1'b0, 2'd2, 1'b0, 'h010, 32'h0, 0, rd, er);
        chk("ld_merged", rd, 32'h80AD_BEEF);
        run(0, 1'b0, 2'd1, 1'b0, 'h011, 32'h0, 0, rd, er);
        chk("half_mis_err", 32'(er), 32'd1);
        chk("half_mis_rd", rd, 32'd0);
        run(0, 1'b1, 2'd2, 1'b0, 'h012, 32'h1234_5678, 0, rd, er);
        chk("word_mis_err", 32'(er), 32'd1);
        run(0, 1'b0, 2'd2, 1'b0, 'h010, 32'h0, 0, rd, er);
        chk("mis_no_write", rd, 32'h80AD_BEEF);
        run(0, 1'b0, 2'd3, 1'b0, 'h010, 32'h0, 0, rd, er);
        chk("size3_err", 32'(er), 32'd1);

        run(1, 1'b1, 2'd2, 1'b0, 'h008, 32'hCAFE_F00D, 0, rd, er);
        run(1, 1'b0, 2'd2, 1'b0, 'h008, 32'h0, 5, rd, er);
        chk("ws3_hold_rd", rd, 32'hCAFE_F00D);
        run(1, 1'b0, 2'd2, 1'b0, 'h03C, 32'h0, 0, rd, er);

        // Reset during WAIT after a store accept.
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b1;
        req_size[1]  = 2'd2;
        req_addr[1]  = 12'h020;
        req_wdata[1] = 32'h0BAD_CAFE;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        model(1, 1'b1, 2'd2, 1'b0, 'h020, 32'h0BAD_CAFE, rd, er);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("mid_rst_ready", 32'(req_ready[1]), 32'd1);
        chk("mid_rst_err", 32'(rsp_err[1]), 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk("mid_rst_valid", 32'(rsp_valid[1]), 32'd0);
            @(posedge clk);
            #1;
        end
        run(1, 1'b0, 2'd2, 1'b0, 'h020, 32'h0, 0, rd, er);
        chk("mid_rst_data", rd, 32'h0BAD_CAFE);

        for (int i = 0; i < 200; i++) begin
            run($urandom_range(0, 1), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 63), $urandom,
                $urandom_range(0, 2), rd, er);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Parametrised data-memory block for the RISC core's load/store unit; successor to the flat word RAM.
- Replaces the shared tristate data bus with separate request and response channels, each using a valid/ready handshake.
- Adds byte-addressed byte, half and word accesses, with byte-lane write strobes and sign/zero extension on loads.
- Adds misalignment error reporting and configurable wait states, so later cache or bus timing can be modelled.

Parameters:
- ADDR_WIDTH, 12: byte-address width. Word depth is derived as 2**(ADDR_WIDTH-2).
- DATA_WIDTH, 32: word width. Fixed at 32 for this generation; any other value is rejected by an elaboration-time check.
- WAIT_STATES, 0: extra cycles inserted between request accept and response, range 0..15.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_rdata  out  DATA_WIDTH  load result, already extended; 0 for stores and errors
- rsp_err  out  1  misaligned or illegal-size access

Behaviour:
- Reset: rst_n sampled low at a clk edge gives:
  - FSM in IDLE, wait counter 0;
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0;
  - memory contents are not cleared.
- FSM states:
  - IDLE: req_ready = 1. Accept occurs on req_valid && req_ready. Go to WAIT if WAIT_STATES > 0, else go to RESP.
  - WAIT: req_ready = 0. Counter loads WAIT_STATES-1 on accept and decrements each cycle. Go to RESP when it reaches 0.
  - RESP: rsp_valid = 1, req_ready = 0. Hold rsp_rdata and rsp_err stable until rsp_valid && rsp_ready, then return to IDLE.
- One outstanding request only. No bypass from RESP to accept in the same cycle, so peak throughput is one access per 2+WAIT_STATES cycles.
- Latency: a request accepted at edge t gives rsp_valid high starting at edge t+1+WAIT_STATES.
- Error check at accept:
  - size 3 is an error;
  - half with addr[0] = 1 is an error;
  - word with addr[1:0] != 0 is an error;
  - on error: no memory write, rsp_err = 1, rsp_rdata = 0.
- Store:
  - Memory is updated at the accept edge; the WAIT period does not delay the write.
  - Byte strobes: byte writes lane addr[1:0]; half writes lanes addr[1]*2 and addr[1]*2+1; word writes all 4 lanes.
  - Lane data is taken from the low bits of req_wdata and shifted into position. Unselected lanes are untouched.
- Load:
  - The word at index addr[ADDR_WIDTH-1:2] is read at the accept edge and the addressed lane(s) are captured.
  - The lane(s) are extended per req_unsigned and registered into rsp_rdata.
  - A load after a store to the same address returns the stored data, since the store commits before any later accept.
- Reset mid-operation: a store accepted before reset stays committed; a pending response is dropped, with no rsp_valid after reset.
- rsp_ready high while rsp_valid is low has no effect. req_* inputs are ignored while req_ready is low.

Decomposition:
- dmem_pkg:
  - typedef enum for access size: SZ_BYTE, SZ_HALF, SZ_WORD;
  - typedef enum for FSM state: IDLE, WAIT, RESP;
  - localparam for lane count (4).
- Sub-module dmem_load_align (combinational): inputs are the raw word, addr[1:0], size and unsigned flag; output is the extended result. The store-strobe logic stays in dmem_ctrl.

Test Plan:
- WAIT_STATES = 0: store word 0xDEADBEEF at 0x010, then load word at 0x010 -> rsp_valid one cycle after each accept; load returns 0xDEADBEEF, rsp_err = 0.
- Store byte 0x80 at 0x013 over that word, then signed byte load at 0x013 -> 0xFFFFFF80; unsigned -> 0x00000080; word load -> 0x80ADBEEF.
- Half load at 0x011 -> rsp_err = 1, rsp_rdata = 0. Store word at 0x012 -> rsp_err = 1 and memory unchanged, checked by a following word load. req_size = 3 -> rsp_err = 1.
- WAIT_STATES = 3: accept at edge t -> rsp_valid first high at t+4; req_ready low from t+1 until response handshake completes.
- Hold rsp_ready low 5 cycles in RESP -> rsp_valid, rsp_rdata, rsp_err stable; req_ready stays 0; no second request accepted.
- Assert rst_n low during WAIT after a store accept -> rsp_valid 0 after reset; later load of that address returns the stored data.
